vmicro16_uart_rx: RTL
=====================

VMICRO16_UART_RX -- requirements
Module: vmicro16_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), clk cycles per UART bit, legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries, power of two 2..16, used only when VMICRO16_UART_RX_FIFO_EN is defined.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data  output  8  received byte at the buffer head, valid only while rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  buffer non-empty.
REQ-008 SHALL have port rx_ready  input  1  consumer pop; a byte is consumed on a cycle with rx_valid=1 and rx_ready=1.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the buffer is full.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized signal rx_s.
REQ-013 SHALL use FSM states IDLE, START, DATA and STOP.
REQ-014 IDLE: SHALL enter START only on a falling edge of rx_s (previous 1, current 0), so a held-low line (break) never retriggers.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), SHALL sample rx_s; 0 -> DATA with bit index 0; 1 -> IDLE (glitch rejected, no pulse).
REQ-016 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles into the shift register LSB first; after the 8th sample -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, SHALL sample rx_s; 1 -> push the byte; 0 -> pulse frame_err, discard the byte; both paths -> IDLE.
REQ-018 The bit-timing counter SHALL be $clog2(CLKS_PER_BIT+1) bits wide, SHALL reload on every state change, and SHALL never wrap.
REQ-019 A pushed byte SHALL appear with rx_valid=1 on the cycle after the stop-bit sample.
REQ-020 Push while full and no pop on the same cycle: SHALL drop the new byte, pulse overrun, and leave buffer contents unchanged.
REQ-021 Push and pop on the same cycle while full: SHALL accept the new byte with no overrun pulse.
REQ-022 rx_data SHALL hold stable while rx_valid=1 and rx_ready=0.
REQ-023 frame_err and overrun SHALL never assert in the same cycle.

Reset
REQ-024 On reset=1 the FSM SHALL go to IDLE, the buffer SHALL empty, and rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0 on the following cycle.
REQ-025 On reset the synchronizer flops and the previous-rx register SHALL load 1 so no false start is detected.
REQ-026 Reset mid-frame SHALL abandon the partial byte; reception SHALL resume on the next falling edge.

Configuration
REQ-027 With VMICRO16_UART_RX_FIFO_EN defined, the buffer SHALL be a FIFO_DEPTH-entry FIFO with rx_data showing the oldest byte.
REQ-028 With VMICRO16_UART_RX_FIFO_EN undefined, the buffer SHALL be a single holding register (depth 1); all other behaviour SHALL be identical.

Structure
REQ-029 Package vmicro16_uart_pkg SHALL hold the FSM state encoding (2 bits), the default CLKS_PER_BIT, and the data width constant 8.
REQ-030 The FIFO SHALL be sub-module vmicro16_uart_fifo, instantiated only under VMICRO16_UART_RX_FIFO_EN; the synchronizer and FSM stay inline.

Verification (bench uses CLKS_PER_BIT=16 unless stated)
REQ-031 Bench SHALL send 0xA5 with rx_ready=1 and require rx_data=0xA5 with rx_valid high for exactly one cycle, and frame_err=0 and overrun=0.
REQ-032 Bench SHALL drive rx low for 4 cycles, then high, and require busy to return to 0 within 12 cycles with no rx_valid and no frame_err.
REQ-033 Bench SHALL send 0x3C with the stop bit at 0 and require a single frame_err pulse, rx_valid=0, and no retrigger while the line stays low.
REQ-034 Bench SHALL hold rx_ready=0 and send 0x11, 0x22, ...; without the macro the 2nd byte SHALL pulse overrun and rx_data SHALL stay 0x11; with the macro (depth 4) the 5th byte SHALL pulse overrun and pops SHALL return 0x11, 0x22, 0x33, 0x44.
REQ-035 Bench SHALL assert reset during bit 3 of 0x5A, then send 0xC3, and require only 0xC3 to be received.
REQ-036 Bench SHALL use CLKS_PER_BIT=434 and send back-to-back 0x00 and 0xFF with rx_ready=1, and require both bytes received in order with no errors.

Source files
------------

// File: rtl/vmicro16_uart_pkg.sv
// vmicro16 UART receiver: shared FSM encoding and constants.
// Optional receive FIFO is enabled with VMICRO16_UART_RX_FIFO_EN.
package vmicro16_uart_pkg;

  localparam int UART_DW      = 8;
  localparam int UART_CPB_DEF = 434;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/vmicro16_uart_fifo.sv
// vmicro16 UART receive FIFO; head word shown on o_data.
// Only instantiated when VMICRO16_UART_RX_FIFO_EN is defined.
module vmicro16_uart_fifo
  import vmicro16_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = UART_DW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CNTW-1:0] r_cnt;
  logic            w_do_pop;
  logic            w_do_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNTW'(DEPTH));
  assign o_data  = r_mem[r_rp];

  // When full, a same-cycle pop frees the head slot the write lands in.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push)
        r_wp <= r_wp + 1'b1;
      if (w_do_pop)
        r_rp <= r_rp + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/vmicro16_uart_rx.sv
// vmicro16 UART 8N1 receiver with one-byte holding register,
// or a FIFO_DEPTH FIFO when VMICRO16_UART_RX_FIFO_EN is defined.
module vmicro16_uart_rx
  import vmicro16_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CPB_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic [UART_DW-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1);

  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_prev;
  logic w_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s;

  uart_rx_state_t     r_state;
  uart_rx_state_t     w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [2:0]         r_bit;
  logic [2:0]         w_bit_nxt;
  logic [UART_DW-1:0] r_shift;
  logic [UART_DW-1:0] w_shift_nxt;
  logic               w_tick;
  logic               w_push;
  logic               w_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    w_tick      = (r_cnt == ((r_state == ST_START) ? HALF_T : FULL_T));
    unique case (r_state)
      ST_IDLE: begin
        if (w_fall)
          w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {r_rx_s, r_shift[UART_DW-1:1]};
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7)
            w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_push      = r_rx_s;
          w_ferr      = ~r_rx_s;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Every non-idle state change happens on a tick, so this reloads on each.
    w_cnt_nxt = ((r_state == ST_IDLE) || w_tick) ? '0 : r_cnt + 1'b1;
  end

  logic               w_pop;
  logic               w_full;
  logic               w_valid;
  logic [UART_DW-1:0] w_head;

  assign w_pop = w_valid & rx_ready;

`ifdef VMICRO16_UART_RX_FIFO_EN
  logic w_empty;

  vmicro16_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_valid = ~w_empty;
`else
  logic [UART_DW-1:0] r_hold;
  logic               r_hold_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
    end else if (w_push && (!r_hold_v || w_pop)) begin
      r_hold   <= r_shift;
      r_hold_v <= 1'b1;
    end else if (w_pop) begin
      r_hold_v <= 1'b0;
    end
  end

  assign w_head  = r_hold;
  assign w_full  = r_hold_v;
  assign w_valid = r_hold_v;
`endif

  logic r_ferr;
  logic r_ovr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_push & w_full & ~w_pop;
    end
  end

  assign rx_valid  = w_valid;
  assign rx_data   = w_valid ? w_head : '0;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != ST_IDLE);

endmodule
